// File: rtl/sand_brush_painter.sv
// Turns mouse samples into square brush strokes written to the game-state RAM.
// One candidate pixel per cycle. Off-screen pixels are skipped. On-screen pixels wait for the arbiter grant.
module sand_brush_painter #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int BRUSH_RADIUS   = 2
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [$clog2(ACTIVE_COLUMNS)-1:0] mouse_x_position_i,
    input  logic [$clog2(ACTIVE_ROWS)-1:0]    mouse_y_position_i,
    input  logic [2:0]                        mouse_btn_i,
    input  logic                              mouse_done_i,
    input  logic                              wr_grant_i,
    output logic                              wr_req_o,
    output logic [ADDR_WIDTH-1:0]             wr_address_o,
    output logic [DATA_WIDTH-1:0]             wr_data_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int XW = $clog2(ACTIVE_COLUMNS);
    localparam int YW = $clog2(ACTIVE_ROWS);
    localparam int OW = $clog2(2 * BRUSH_RADIUS + 1) + 1;

    localparam logic signed [OW-1:0]   R_POS      = OW'(BRUSH_RADIUS);
    localparam logic signed [OW-1:0]   R_NEG      = OW'(-BRUSH_RADIUS);
    localparam logic signed [OW-1:0]   ONE        = OW'(1);
    localparam logic [XW:0]            COLS_U     = XW'(ACTIVE_COLUMNS) == '0 ? '0 : (XW+1)'(ACTIVE_COLUMNS);
    localparam logic [YW:0]            ROWS_U     = (YW+1)'(ACTIVE_ROWS);
    localparam logic [ADDR_WIDTH-1:0]  ROW_STRIDE = ADDR_WIDTH'(ACTIVE_COLUMNS);
    localparam logic [ADDR_WIDTH-1:0]  TOP_OFFSET = ADDR_WIDTH'(BRUSH_RADIUS * ACTIVE_COLUMNS);

    typedef enum logic [1:0] {IDLE, LATCH, PAINT, FINISH} state_t;

    state_t                  state_reg, state_next;
    logic [XW-1:0]           x_reg;
    logic [YW-1:0]           y_reg;
    logic                    sand_reg;
    logic signed [OW-1:0]    dx_reg, dy_reg;
    logic [ADDR_WIDTH-1:0]   row_base_reg;

    logic                    start;
    logic signed [XW:0]      cand_x;
    logic signed [YW:0]      cand_y;
    logic                    x_in_bounds, y_in_bounds, in_bounds;
    logic                    candidate_last;
    logic                    advance;
    logic                    unused_middle_btn;

    // The middle button alone never paints.
    assign unused_middle_btn = mouse_btn_i[2];
    assign start = mouse_done_i && (mouse_btn_i[0] || mouse_btn_i[1]);

    assign cand_x = $signed({1'b0, x_reg}) + (XW+1)'(dx_reg);
    assign cand_y = $signed({1'b0, y_reg}) + (YW+1)'(dy_reg);

    // The sign bit catches both negative results and any positive overflow.
    assign x_in_bounds = !cand_x[XW] && ({1'b0, cand_x[XW-1:0]} < COLS_U);
    assign y_in_bounds = !cand_y[YW] && ({1'b0, cand_y[YW-1:0]} < ROWS_U);
    assign in_bounds   = x_in_bounds && y_in_bounds;

    assign candidate_last = (dx_reg == R_POS) && (dy_reg == R_POS);
    assign advance        = !in_bounds || wr_grant_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LATCH;
            LATCH:   state_next = PAINT;
            PAINT:   if (advance && candidate_last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_req_o     = 1'b0;
        wr_address_o = '0;
        wr_data_o    = '0;
        busy_o       = (state_reg != IDLE);
        done_o       = (state_reg == FINISH);
        if (state_reg == PAINT && in_bounds) begin
            wr_req_o     = 1'b1;
            wr_address_o = row_base_reg + ADDR_WIDTH'(cand_x[XW-1:0]);
            wr_data_o    = {DATA_WIDTH{sand_reg}};
        end
    end

    // The row base is kept modulo 2^ADDR_WIDTH. It can wrap for rows above the screen.
    // It becomes exact again before any on-screen row is reached.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_reg        <= '0;
            y_reg        <= '0;
            sand_reg     <= 1'b0;
            dx_reg       <= '0;
            dy_reg       <= '0;
            row_base_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg    <= mouse_x_position_i;
                        y_reg    <= mouse_y_position_i;
                        sand_reg <= mouse_btn_i[0];
                    end
                end
                LATCH: begin
                    dx_reg       <= R_NEG;
                    dy_reg       <= R_NEG;
                    row_base_reg <= ADDR_WIDTH'(y_reg) * ROW_STRIDE - TOP_OFFSET;
                end
                PAINT: begin
                    if (advance) begin
                        if (dx_reg == R_POS) begin
                            dx_reg       <= R_NEG;
                            dy_reg       <= dy_reg + ONE;
                            row_base_reg <= row_base_reg + ROW_STRIDE;
                        end else begin
                            dx_reg <= dx_reg + ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sand_brush_painter.sv
// Directed checks of brush strokes, bounds clipping, grant stalls, dropped strobes and reset.
module tb_sand_brush_painter;

    localparam int COLS = 640;
    localparam int ROWS = 480;
    localparam int R    = 2;
    localparam int AW   = $clog2(COLS * ROWS);

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    mx;
    logic [8:0]    my;
    logic [2:0]    btn;
    logic          mdone;
    logic          grant;
    logic          req;
    logic [AW-1:0] addr;
    logic [0:0]    data;
    logic          busy;
    logic          done;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sand_brush_painter dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .mouse_x_position_i (mx),
        .mouse_y_position_i (my),
        .mouse_btn_i        (btn),
        .mouse_done_i       (mdone),
        .wr_grant_i         (grant),
        .wr_req_o           (req),
        .wr_address_o       (addr),
        .wr_data_o          (data),
        .busy_o             (busy),
        .done_o             (done)
    );

    task automatic check(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a strobe in cycle t and returns positioned in cycle t+1.
    task automatic strobe(input int x, input int y, input logic [2:0] b);
        mx    = 10'(x);
        my    = 9'(y);
        btn   = b;
        mdone = 1'b1;
        step();
        mdone = 1'b0;
    endtask

    task automatic run_stroke(input int x, input int y, input logic [2:0] b,
                              input int exp_data, input int exp_writes,
                              input int exp_last, input int drop_at);
        int idx;
        int dut_writes;
        int last_addr;
        int over_range;
        int cx;
        int cy;
        int inb;
        idx        = 0;
        dut_writes = 0;
        last_addr  = -1;
        over_range = 0;
        grant      = 1'b1;
        strobe(x, y, b);
        check("latch_busy", int'(busy), 1);
        check("latch_req", int'(req), 0);
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                step();
                mdone = 1'b0;
                cx  = x + dx;
                cy  = y + dy;
                inb = (cx >= 0 && cx < COLS && cy >= 0 && cy < ROWS) ? 1 : 0;
                check("cand_req", int'(req), inb);
                if (inb == 1) begin
                    check("cand_addr", int'(addr), cy * COLS + cx);
                    check("cand_data", int'(data), exp_data);
                end
                check("cand_busy", int'(busy), 1);
                if (req) begin
                    dut_writes++;
                    last_addr = int'(addr);
                    if (int'(addr) >= COLS * ROWS) over_range++;
                end
                if (idx == drop_at) begin
                    mx    = 10'd5;
                    my    = 9'd5;
                    btn   = 3'b001;
                    mdone = 1'b1;
                end
                idx++;
            end
        end
        step();
        mdone = 1'b0;
        check("finish_done", int'(done), 1);
        check("finish_req", int'(req), 0);
        check("finish_busy", int'(busy), 1);
        check("write_count", dut_writes, exp_writes);
        check("last_addr", last_addr, exp_last);
        check("addr_range", over_range, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_done", int'(done), 0);
            check("idle_busy", int'(busy), 0);
            check("idle_req", int'(req), 0);
        end
        $display("[TB] stroke (%0d,%0d) btn=%b writes=%0d last=%0d", x, y, b, dut_writes, last_addr);
    endtask

    initial begin
        int stray;
        reset = 1'b1;
        mx    = '0;
        my    = '0;
        btn   = '0;
        mdone = 1'b0;
        grant = 1'b0;
        step();
        step();
        check("reset_req", int'(req), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_addr", int'(addr), 0);
        check("reset_data", int'(data), 0);
        reset = 1'b0;
        step();
        $display("[TB] reset state checked");

        run_stroke(100, 100, 3'b001, 1, 25, 102 * COLS + 102, -1);
        run_stroke(0, 0, 3'b010, 0, 9, 1282, -1);
        run_stroke(639, 479, 3'b011, 1, 9, 307199, -1);

        // Grant held low for five cycles on the first request.
        strobe(100, 100, 3'b001);
        grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_req", int'(req), 1);
            check("stall_addr", int'(addr), 62818);
        end
        step();
        grant = 1'b1;
        check("grant_addr", int'(addr), 62818);
        step();
        check("advance_addr", int'(addr), 62819);
        for (int i = 0; i < 23; i++) step();
        check("stall_pre_done", int'(done), 0);
        step();
        check("stall_done", int'(done), 1);
        step();
        check("stall_idle", int'(busy), 0);
        $display("[TB] stalled stroke done at t+32");

        // Strobes with no paint button must be ignored.
        strobe(50, 50, 3'b000);
        check("nobtn_busy", int'(busy), 0);
        step();
        check("nobtn_req", int'(req), 0);
        strobe(50, 50, 3'b100);
        check("midbtn_busy", int'(busy), 0);
        step();
        check("midbtn_req", int'(req), 0);
        $display("[TB] ignored strobes checked");

        run_stroke(100, 100, 3'b001, 1, 25, 102 * COLS + 102, 5);

        // Reset in the middle of a stroke.
        grant = 1'b1;
        strobe(200, 200, 3'b001);
        for (int i = 0; i < 10; i++) step();
        check("pre_reset_req", int'(req), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("post_reset_req", int'(req), 0);
        check("post_reset_busy", int'(busy), 0);
        check("post_reset_done", int'(done), 0);
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done || req || busy) stray++;
        end
        check("post_reset_quiet", stray, 0);
        $display("[TB] mid-stroke reset checked");

        run_stroke(300, 200, 3'b001, 1, 25, 202 * COLS + 302, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/sand_brush_painter.md
Name: sand_brush_painter

Overview:
Converts mouse position and button state into brush writes on the game-state RAM write port. On each new mouse sample with a paint button held, it walks a square brush centred on the cursor. It issues one RAM write per on-screen pixel through a request/grant handshake, so a write arbiter can interleave these writes with game_state_controller's simulation writes. It sits between mouse_position_tracker and the game-state RAM write arbiter.

Parameters:
ACTIVE_COLUMNS, 640, screen width in pixels
ACTIVE_ROWS, 480, screen height in pixels
ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), RAM address width
DATA_WIDTH, 1, RAM word width
BRUSH_RADIUS, 2, brush half-width R; the brush is (2R+1)x(2R+1) pixels

Ports:
clk_i  input  1  system clock; the block uses only this clock
reset_i  input  1  synchronous, active-high reset
mouse_x_position_i  input  $clog2(ACTIVE_COLUMNS)  cursor column
mouse_y_position_i  input  $clog2(ACTIVE_ROWS)  cursor row
mouse_btn_i  input  3  mouse buttons: [0] left, [1] right, [2] middle
mouse_done_i  input  1  one-cycle strobe marking a new mouse sample
wr_grant_i  input  1  arbiter accepts the current request this cycle
wr_req_o  output  1  write request
wr_address_o  output  ADDR_WIDTH  write address, equal to y*ACTIVE_COLUMNS + x
wr_data_o  output  DATA_WIDTH  write data: all ones = sand, all zeros = erase
busy_o  output  1  high whenever the state is not IDLE
done_o  output  1  one-cycle pulse when a brush stroke completes

Behaviour:
- Reset (synchronous, reset_i high at a clock edge): state goes to IDLE. wr_req_o, busy_o and done_o are 0. wr_address_o and wr_data_o are 0. Reset has priority over everything. Reset during PAINT aborts the stroke immediately, and no further request is issued.
- States: IDLE, LATCH, PAINT, FINISH.
- IDLE: if mouse_done_i is high at cycle t and (btn[0] or btn[1]) is high:
  - capture x, y and the colour; btn[0] gives sand and wins over btn[1]; btn[1] alone gives erase;
  - btn[2] alone is ignored;
  - go to LATCH at t+1.
- LATCH: dy = -R, dx = -R. Compute the row base (y+dy)*ACTIVE_COLUMNS into a register. Go to PAINT.
- PAINT: one candidate pixel (x+dx, y+dy) per visit, scanned row-major (dy outer, dx inner, both ascending -R..+R).
  - The first candidate is presented at t+2.
  - Out of bounds means x+dx < 0, x+dx >= ACTIVE_COLUMNS, y+dy < 0 or y+dy >= ACTIVE_ROWS. Use signed arithmetic one bit wider than the coordinate.
  - An out-of-bounds candidate is skipped. It takes exactly one cycle with wr_req_o = 0.
  - An in-bounds candidate drives wr_req_o = 1 with its address and data. The write is performed in the cycle where wr_req_o and wr_grant_i are both 1.
  - While the grant is low, wr_req_o, wr_address_o and wr_data_o hold stable.
  - After a grant or a skip, advance to the next candidate on the next cycle. Grant-tied-high throughput is one pixel per cycle.
  - After the last candidate (dx = dy = +R) retires, go to FINISH.
- FINISH: done_o = 1 for exactly one cycle, then return to IDLE. wr_req_o = 0.
- wr_grant_i is ignored whenever wr_req_o = 0.
- mouse_done_i arriving in LATCH, PAINT or FINISH is dropped. No queueing.
- The centre coordinates are latched, so input changes mid-stroke have no effect.
- Addresses are always < ACTIVE_COLUMNS*ACTIVE_ROWS. No write wraps to an adjacent row.
- Stroke length: (2R+1)^2 candidate cycles plus grant stalls. With the grant tied high and R = 2, done_o pulses at t+27.

Test Plan:
- Centre (100,100), left button, grant tied high, strobe at t -> 25 writes on t+2..t+26, addresses (98..102)+640*(98..102) in row-major order, data 1, done_o at t+27, busy_o high t+1..t+27.
- Corner (0,0), right button only, grant tied high -> 9 writes to x 0..2, y 0..2 (addresses 0,1,2,640,641,642,1280,1281,1282), data 0, 16 skip cycles with req low, done_o at t+27.
- Corner (639,479), both buttons -> 9 writes covering x 637..639, y 477..479, last address 307199, data 1; no address >= 307200.
- Grant held low for 5 cycles on the first request at (100,100) -> wr_req_o stays 1 and address stays 62818 for 5 cycles; it advances to 62819 the cycle after the grant; done_o is delayed by 5 cycles to t+32.
- Strobe with btn = 3'b000 or 3'b100; a second strobe during PAINT; and reset_i high mid-PAINT -> no request is issued for the ignored or dropped strobes. After reset: next cycle wr_req_o = 0, busy_o = 0, no done_o pulse, and a new stroke starts normally.
